lcd_ctrl: RTL and testbench

LCD_CTRL -- requirements
Module: lcd_ctrl

---
 rtl/lcd_pkg.sv | 32 +++
 rtl/lcd_tmr.sv | 35 +++
 rtl/lcd_ctrl.sv | 159 +++++++++++++++
 tb/tb_lcd_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 write-only LCD controller.
package lcd_pkg;

    typedef enum logic [2:0] {
        StPwrup,
        StInit,
        StIdle,
        StSetup,
        StEnable,
        StHold,
        StExec
    } lcd_state_e;

    localparam int unsigned InitLen = 4;

    // Function set 8-bit/2-line, display on, clear, entry mode increment.
    // Element 0 is sent first.
    localparam logic [InitLen-1:0][7:0] InitSeq = {8'h06, 8'h01, 8'h0C, 8'h38};

    localparam int unsigned DefTPwrup = 540000;
    localparam int unsigned DefTSetup = 2;
    localparam int unsigned DefTEn    = 8;
    localparam int unsigned DefTHold  = 2;
    localparam int unsigned DefTExec  = 1080;
    localparam int unsigned DefTClear = 44280;

    // Clear display / return home need the long execute time.
    function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data[7:2] == 6'd0);
    endfunction

endpackage

// File: rtl/lcd_tmr.sv
// Loadable down-counter; done_o flags the last cycle of the loaded interval.
module lcd_tmr #(
    parameter int unsigned Width  = 16,
    parameter int unsigned RstVal = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic             done_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    // Parks at 1 so done_o stays high while nothing is timed.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q > Width'(1)) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= Width'(RstVal);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == Width'(1));

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 8-bit write-only controller: power-up wait, fixed init sequence,
// then single-byte command/data writes with setup, enable, hold and execute timing.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned T_PWRUP = DefTPwrup,
    parameter int unsigned T_SETUP = DefTSetup,
    parameter int unsigned T_EN    = DefTEn,
    parameter int unsigned T_HOLD  = DefTHold,
    parameter int unsigned T_EXEC  = DefTExec,
    parameter int unsigned T_CLEAR = DefTClear
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       init_done,
    output logic [7:0] lcd_data,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic       lcd_rs,
    output logic       lcd_on
);

    localparam int unsigned MaxPc  = (T_PWRUP > T_CLEAR) ? T_PWRUP : T_CLEAR;
    localparam int unsigned CntMax = (MaxPc > T_EXEC) ? MaxPc : T_EXEC;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned IdxW   = $clog2(InitLen);

    lcd_state_e      state_q, state_d;
    logic [7:0]      lcd_data_q, lcd_data_d;
    logic            lcd_rs_q, lcd_rs_d;
    logic            lcd_en_q, lcd_en_d;
    logic            lcd_on_q;
    logic            init_done_q, init_done_d;
    logic [IdxW-1:0] init_idx_q, init_idx_d;
    logic [IdxW-1:0] init_idx_nxt;

    logic            tmr_load;
    logic [CntW-1:0] tmr_val;
    logic            tmr_done;

    lcd_tmr #(
        .Width  (CntW),
        .RstVal (T_PWRUP)
    ) u_tmr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    assign init_idx_nxt = init_idx_q + IdxW'(1);

    // Every transition happens on the timer's last cycle and reloads it for the new state.
    always_comb begin
        state_d     = state_q;
        lcd_data_d  = lcd_data_q;
        lcd_rs_d    = lcd_rs_q;
        lcd_en_d    = lcd_en_q;
        init_done_d = init_done_q;
        init_idx_d  = init_idx_q;
        tmr_load    = 1'b0;
        tmr_val     = '0;

        unique case (state_q)
            StPwrup: begin
                if (tmr_done) begin
                    state_d    = StInit;
                    lcd_rs_d   = 1'b0;
                    lcd_data_d = InitSeq[0];
                    init_idx_d = '0;
                    tmr_load   = 1'b1;
                    tmr_val    = CntW'(T_SETUP);
                end
            end
            StIdle: begin
                if (req_valid && init_done_q) begin
                    state_d    = StSetup;
                    lcd_rs_d   = req_rs;
                    lcd_data_d = req_data;
                    tmr_load   = 1'b1;
                    tmr_val    = CntW'(T_SETUP);
                end
            end
            StInit, StSetup: begin
                if (tmr_done) begin
                    state_d  = StEnable;
                    lcd_en_d = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = CntW'(T_EN);
                end
            end
            StEnable: begin
                if (tmr_done) begin
                    state_d  = StHold;
                    lcd_en_d = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = CntW'(T_HOLD);
                end
            end
            StHold: begin
                if (tmr_done) begin
                    state_d  = StExec;
                    tmr_load = 1'b1;
                    tmr_val  = is_slow_cmd(lcd_rs_q, lcd_data_q) ? CntW'(T_CLEAR)
                                                                 : CntW'(T_EXEC);
                end
            end
            StExec: begin
                if (tmr_done) begin
                    if (init_done_q || (init_idx_q == IdxW'(InitLen - 1))) begin
                        state_d     = StIdle;
                        init_done_d = 1'b1;
                    end else begin
                        state_d    = StInit;
                        init_idx_d = init_idx_nxt;
                        lcd_data_d = InitSeq[init_idx_nxt];
                        tmr_load   = 1'b1;
                        tmr_val    = CntW'(T_SETUP);
                    end
                end
            end
            default: state_d = StPwrup;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StPwrup;
            lcd_data_q  <= 8'h00;
            lcd_rs_q    <= 1'b0;
            lcd_en_q    <= 1'b0;
            lcd_on_q    <= 1'b0;
            init_done_q <= 1'b0;
            init_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            lcd_data_q  <= lcd_data_d;
            lcd_rs_q    <= lcd_rs_d;
            lcd_en_q    <= lcd_en_d;
            lcd_on_q    <= 1'b1;
            init_done_q <= init_done_d;
            init_idx_q  <= init_idx_d;
        end
    end

    assign req_ready = (state_q == StIdle) && init_done_q;
    assign init_done = init_done_q;
    assign lcd_data  = lcd_data_q;
    assign lcd_rs    = lcd_rs_q;
    assign lcd_en    = lcd_en_q;
    assign lcd_rw    = 1'b0;
    assign lcd_on    = lcd_on_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Scoreboard bench for lcd_ctrl: expected EN pulses are queued by the stimulus
// and popped by an independent monitor watching lcd_en.
module tb_lcd_ctrl;

    localparam int unsigned TPwrup = 100;
    localparam int unsigned TSetup = 2;
    localparam int unsigned TEn    = 8;
    localparam int unsigned THold  = 2;
    localparam int unsigned TExec  = 20;
    localparam int unsigned TClear = 60;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_rs = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       req_ready, init_done, lcd_rw, lcd_en, lcd_rs, lcd_on;
    logic [7:0] lcd_data;

    lcd_ctrl #(
        .T_PWRUP (TPwrup),
        .T_SETUP (TSetup),
        .T_EN    (TEn),
        .T_HOLD  (THold),
        .T_EXEC  (TExec),
        .T_CLEAR (TClear)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_rs    (req_rs),
        .req_data  (req_data),
        .req_ready (req_ready),
        .init_done (init_done),
        .lcd_data  (lcd_data),
        .lcd_rw    (lcd_rw),
        .lcd_en    (lcd_en),
        .lcd_rs    (lcd_rs),
        .lcd_on    (lcd_on)
    );

    always #5 clk = ~clk;

    // Edge number since the last reset release (first edge after release is 1).
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    typedef struct packed {
        logic        rs;
        logic [7:0]  data;
        logic [31:0] rise;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [7:0] init_bytes [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

    // Busy time of one write, from the accepting edge to the edge restoring ready.
    function automatic int unsigned write_len(input logic rs, input logic [7:0] data);
        return TSetup + TEn + THold + ((!rs && data < 8'd4) ? TClear : TExec);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push_init(output int unsigned done_cyc);
        int unsigned t;
        exp_t e;
        t = TPwrup;
        for (int i = 0; i < 4; i++) begin
            e.rs = 1'b0;
            e.data = init_bytes[i];
            e.rise = t + TSetup;
            exp_q.push_back(e);
            t += write_len(1'b0, init_bytes[i]);
        end
        done_cyc = t;
    endtask

    task automatic wait_init(input int unsigned expv);
        int n;
        n = 0;
        while (!init_done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("init_done_time", cyc, expv);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!req_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic send(input logic rs, input logic [7:0] data, input bit junk);
        int unsigned k;
        exp_t e;
        wait_ready();
        if (!req_ready) begin
            check("ready_wait", 32'(req_ready), 32'd1);
            return;
        end
        req_valid = 1'b1;
        req_rs = rs;
        req_data = data;
        k = cyc + 1;
        e.rs = rs;
        e.data = data;
        e.rise = k + TSetup;
        exp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        req_rs = 1'($urandom);
        req_data = 8'($urandom);
        check("accept_latch", 32'({lcd_rs, lcd_data}), 32'({rs, data}));
        if (junk) begin
            repeat (3) @(negedge clk);
            req_valid = 1'b1;
            req_rs = ~rs;
            req_data = ~data;
            @(negedge clk);
            req_valid = 1'b0;
            repeat ($urandom_range(5, 15)) @(negedge clk);
            req_valid = 1'b1;
            @(negedge clk);
            req_valid = 1'b0;
        end
        wait_ready();
        check("ready_return", cyc, k + write_len(rs, data));
    endtask

    task automatic send_stream(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0]  b [3];
        int unsigned ks [3];
        int unsigned k;
        int          n;
        exp_t        e;
        b[0] = b0;
        b[1] = b1;
        b[2] = b2;
        wait_ready();
        k = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            ks[i] = k;
            e.rs = 1'b1;
            e.data = b[i];
            e.rise = k + TSetup;
            exp_q.push_back(e);
            k += write_len(1'b1, b[i]) + 1;
        end
        req_valid = 1'b1;
        req_rs = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_data = b[i];
            n = 0;
            while (cyc < ks[i] && n < 500) begin
                @(negedge clk);
                n++;
            end
        end
        req_valid = 1'b0;
        wait_ready();
        check("stream_ready", cyc, ks[2] + write_len(1'b1, b[2]));
    endtask

    // Monitor: each EN rise consumes one expected write.
    initial begin
        logic en_prev, tracking, stable;
        int   en_len, low_cnt;
        exp_t cur;
        en_prev = 1'b0;
        tracking = 1'b0;
        stable = 1'b0;
        en_len = 0;
        low_cnt = 0;
        cur = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                en_prev = 1'b0;
                tracking = 1'b0;
                continue;
            end
            if (lcd_en && !en_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: EN rose at cycle %0d rs=%0b data=%02h, none expected",
                             cyc, lcd_rs, lcd_data);
                    tracking = 1'b0;
                end else begin
                    cur = exp_q.pop_front();
                    check("pulse_byte", 32'({lcd_rs, lcd_data}), 32'({cur.rs, cur.data}));
                    check("pulse_start", cyc, cur.rise);
                    check("lcd_rw", 32'(lcd_rw), 32'd0);
                    tracking = 1'b1;
                    stable = 1'b1;
                    en_len = 0;
                    low_cnt = 0;
                end
            end
            if (tracking) begin
                if ({lcd_rs, lcd_data} !== {cur.rs, cur.data}) stable = 1'b0;
                if (lcd_en) begin
                    en_len++;
                end else begin
                    if (low_cnt == 0) check("pulse_width", en_len, TEn);
                    low_cnt++;
                    if (low_cnt == int'(THold)) begin
                        check("hold_stable", 32'(stable), 32'd1);
                        tracking = 1'b0;
                    end
                end
            end
            en_prev = lcd_en;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned init_exp;
        logic        rs;
        logic [7:0]  data;
        int          n;
        exp_t        e;

        repeat (3) @(negedge clk);
        check("rst_lcd_en", 32'(lcd_en), 32'd0);
        check("rst_lcd_rs", 32'(lcd_rs), 32'd0);
        check("rst_lcd_data", 32'(lcd_data), 32'h00);
        check("rst_lcd_rw", 32'(lcd_rw), 32'd0);
        check("rst_lcd_on", 32'(lcd_on), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);

        rst_n = 1'b1;
        push_init(init_exp);
        @(negedge clk);
        check("lcd_on_after_release", 32'(lcd_on), 32'd1);
        check("ready_during_pwrup", 32'(req_ready), 32'd0);
        wait_init(init_exp);

        send(1'b1, 8'h41, 1'b0);
        send(1'b0, 8'h01, 1'b0);
        send(1'b0, 8'h04, 1'b0);
        send_stream(8'h48, 8'h49, 8'h21);
        send(1'b1, 8'h55, 1'b1);

        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                rs = 1'b0;
                data = 8'($urandom_range(0, 3));
            end else begin
                rs = 1'($urandom);
                data = 8'($urandom);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(rs, data, 1'($urandom));
        end

        // Reset in the middle of an EN pulse.
        wait_ready();
        req_valid = 1'b1;
        req_rs = 1'b1;
        req_data = 8'h5A;
        e.rs = 1'b1;
        e.data = 8'h5A;
        e.rise = cyc + 1 + TSetup;
        exp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!lcd_en && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("en_before_reset", 32'(lcd_en), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("reset_drops_en", 32'(lcd_en), 32'd0);
        check("reset_init_done", 32'(init_done), 32'd0);
        check("reset_ready", 32'(req_ready), 32'd0);
        check("reset_lcd_data", 32'(lcd_data), 32'h00);
        check("reset_lcd_on", 32'(lcd_on), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_init(init_exp);
        wait_init(init_exp);

        send(1'b1, 8'h42, 1'b0);
        repeat (10) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
